prng_health_monitor: RTL

//   Online health test that consumes the 128-bit word stream of the NLFSR PRNG.

---
 rtl/prng_health_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/prng_health_monitor.sv
// Online health monitor for the PRNG word stream: repetition-count and adaptive-proportion
// (monobit) tests with sticky failure flags that must be cleared explicitly.
module prng_health_monitor #(
  parameter int unsigned WIDTH        = 128,
  parameter int unsigned WINDOW_WORDS = 64,
  parameter int unsigned ONES_LO      = 3892,
  parameter int unsigned ONES_HI      = 4300,
  parameter int unsigned REP_LIMIT    = 3,
  localparam int unsigned CW          = $clog2(WIDTH * WINDOW_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             window_done,
  output logic [CW-1:0]    ones_count,
  output logic             fail_rep,
  output logic             fail_prop
);

  localparam int unsigned PW  = $clog2(WIDTH + 1);
  localparam int unsigned WCW = $clog2(WINDOW_WORDS + 1);
  localparam int unsigned RCW = $clog2(REP_LIMIT + 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StCheck, StFail} state_e;

  state_e             state_q;
  logic [PW-1:0]      pc_q;
  logic               pc_vld_q;
  logic [CW-1:0]      acc_q;
  logic [WCW-1:0]     word_cnt_q;
  logic [WIDTH-1:0]   prev_q;
  logic               prev_vld_q;
  logic [RCW-1:0]     rep_cnt_q;
  logic               drain_q;

  logic               accept;
  logic [RCW-1:0]     rep_next;
  logic               rep_hit;
  logic               acc_in_range;

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PW'(w[i]);
    end
    return n;
  endfunction

  assign in_ready     = (state_q == StRun);
  assign accept       = in_valid && in_ready;
  assign rep_next     = (prev_vld_q && (in_data == prev_q)) ? rep_cnt_q + RCW'(1) : RCW'(1);
  assign rep_hit      = accept && (rep_next == RCW'(REP_LIMIT));
  assign acc_in_range = (acc_q >= CW'(ONES_LO)) && (acc_q <= CW'(ONES_HI));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      pc_vld_q    <= 1'b0;
      acc_q       <= '0;
      word_cnt_q  <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      rep_cnt_q   <= '0;
      drain_q     <= 1'b0;
      window_done <= 1'b0;
      ones_count  <= '0;
      fail_rep    <= 1'b0;
      fail_prop   <= 1'b0;
    end else begin
      window_done <= 1'b0;
      pc_vld_q    <= accept;
      if (accept) begin
        pc_q       <= popcount(in_data);
        prev_q     <= in_data;
        prev_vld_q <= 1'b1;
        rep_cnt_q  <= rep_next;
        word_cnt_q <= word_cnt_q + WCW'(1);
      end
      if (pc_vld_q) begin
        acc_q <= acc_q + CW'(pc_q);
      end

      unique case (state_q)
        StIdle: begin
          // Holding everything cleared here means every path into IDLE discards the window.
          acc_q      <= '0;
          word_cnt_q <= '0;
          pc_vld_q   <= 1'b0;
          prev_vld_q <= 1'b0;
          rep_cnt_q  <= '0;
          if (clr) begin
            fail_rep  <= 1'b0;
            fail_prop <= 1'b0;
          end else if (enable) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (clr) begin
            state_q   <= StIdle;
            fail_rep  <= 1'b0;
            fail_prop <= 1'b0;
          end else if (rep_hit) begin
            fail_rep <= 1'b1;
            state_q  <= StFail;
          end else if (!enable) begin
            state_q <= StIdle;
          end else if (accept && (word_cnt_q == WCW'(WINDOW_WORDS - 1))) begin
            state_q <= StDrain;
            drain_q <= 1'b0;
          end
        end
        StDrain: begin
          if (clr) begin
            state_q   <= StIdle;
            fail_rep  <= 1'b0;
            fail_prop <= 1'b0;
          end else if (!enable) begin
            state_q <= StIdle;
          end else if (drain_q) begin
            state_q <= StCheck;
          end else begin
            drain_q <= 1'b1;
          end
        end
        StCheck: begin
          if (clr) begin
            state_q   <= StIdle;
            fail_rep  <= 1'b0;
            fail_prop <= 1'b0;
          end else if (!enable) begin
            state_q <= StIdle;
          end else begin
            ones_count  <= acc_q;
            window_done <= 1'b1;
            if (acc_in_range) begin
              acc_q      <= '0;
              word_cnt_q <= '0;
              state_q    <= StRun;
            end else begin
              fail_prop <= 1'b1;
              state_q   <= StFail;
            end
          end
        end
        StFail: begin
          if (clr) begin
            state_q   <= StIdle;
            fail_rep  <= 1'b0;
            fail_prop <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
